codma_task_scheduler: RTL and testbench

Front-end scheduler for the `codma_machine` DMA engine. It accepts task pointers from up to NUM_REQ requesters through a round-robin arbiter and holds them in a FIFO. It dispatches tasks one at a time over the engine's `start`/`busy` handshake, then reports completion, or a start timeout, tagged with the originating requester id.

---
 rtl/codma_task_scheduler_if.sv | 34 +++
 rtl/codma_task_scheduler.sv | 157 +++++++++++++++
 tb/tb_codma_task_scheduler.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/codma_task_scheduler_if.sv
// Requester, DMA-engine and completion signals of the codma task scheduler.
// The master modport is the scheduler side; slave is its environment.
interface codma_task_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 8
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                      enable_i;
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0][31:0]  req_pointer_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      start_o;
  logic [31:0]               task_pointer_o;
  logic                      busy_i;
  logic                      done_valid_o;
  logic [ID_W-1:0]           done_id_o;
  logic                      done_err_o;
  logic                      error_o;
  logic [CNT_W-1:0]          queue_count_o;

  modport master (
    input  enable_i, req_valid_i, req_pointer_i, busy_i,
    output req_ready_o, start_o, task_pointer_o, done_valid_o,
           done_id_o, done_err_o, error_o, queue_count_o
  );

  modport slave (
    output enable_i, req_valid_i, req_pointer_i, busy_i,
    input  req_ready_o, start_o, task_pointer_o, done_valid_o,
           done_id_o, done_err_o, error_o, queue_count_o
  );
endinterface

// File: rtl/codma_task_scheduler.sv
// Round-robin task intake, task FIFO and start/busy dispatch front-end
// for the codma_machine DMA engine.
module codma_task_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int DEPTH         = 8,
  parameter int START_TIMEOUT = 16
) (
  input logic                    clk_i,
  input logic                    reset_n_i,
  codma_task_scheduler_if.master bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TW    = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam int EW    = ID_W + 32;

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    scan_idx;
  logic [ID_W-1:0]    cur_id;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [TW-1:0]      timer;
  logic [EW-1:0]      mem [DEPTH];
  logic [EW-1:0]      head;

  logic               start_q;
  logic [31:0]        task_pointer_q;
  logic               done_valid_q;
  logic [ID_W-1:0]    done_id_q;
  logic               done_err_q;
  logic               error_q;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = grant_any;
  assign pop   = (state == IDLE) && bus.enable_i && !empty;
  assign head  = mem[rd_ptr];

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    scan_idx  = '0;
    if (!full) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        scan_idx = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
        if (!grant_any && bus.req_valid_i[scan_idx]) begin
          grant[scan_idx] = 1'b1;
          grant_id        = scan_idx;
          grant_any       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {grant_id, bus.req_pointer_i[grant_id]};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state          <= IDLE;
      timer          <= '0;
      cur_id         <= '0;
      start_q        <= 1'b0;
      task_pointer_q <= '0;
      done_valid_q   <= 1'b0;
      done_id_q      <= '0;
      done_err_q     <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            task_pointer_q <= head[31:0];
            cur_id         <= head[EW-1:32];
            start_q        <= 1'b1;
            timer          <= '0;
            state          <= START;
          end
        end
        START: begin
          if (bus.busy_i) begin
            start_q <= 1'b0;
            timer   <= '0;
            state   <= RUN;
          end else if (timer == TW'(START_TIMEOUT - 1)) begin
            start_q      <= 1'b0;
            timer        <= '0;
            error_q      <= 1'b1;
            done_valid_q <= 1'b1;
            done_id_q    <= cur_id;
            done_err_q   <= 1'b1;
            state        <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RUN: begin
          if (!bus.busy_i) begin
            done_valid_q <= 1'b1;
            done_id_q    <= cur_id;
            done_err_q   <= 1'b0;
            state        <= DONE;
          end
        end
        DONE: begin
          done_valid_q <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o    = grant;
  assign bus.start_o        = start_q;
  assign bus.task_pointer_o = task_pointer_q;
  assign bus.done_valid_o   = done_valid_q;
  assign bus.done_id_o      = done_id_q;
  assign bus.done_err_o     = done_err_q;
  assign bus.error_o        = error_q;
  assign bus.queue_count_o  = count;
endmodule

// File: tb/tb_codma_task_scheduler.sv
// Directed and randomized bench for codma_task_scheduler with a queue-based
// reference model and a simple DMA engine model driving busy_i.
module tb_codma_task_scheduler;
  localparam int NUM_REQ       = 4;
  localparam int DEPTH         = 8;
  localparam int START_TIMEOUT = 16;
  localparam int ID_W          = $clog2(NUM_REQ);

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  codma_task_scheduler_if #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH)) bus ();

  codma_task_scheduler #(
    .NUM_REQ(NUM_REQ),
    .DEPTH(DEPTH),
    .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  longint cyc  = 0;

  logic [ID_W+31:0] q[$];
  int               rr;
  bit               inflight;
  bit               started;
  int               age;
  logic [ID_W-1:0]  infl_id;
  logic [31:0]      infl_ptr;
  longint           idle_from;
  bit               sticky;

  bit eng_alive = 1'b1;
  int eng_len   = 5;
  int busy_cnt  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    rr        = 0;
    inflight  = 1'b0;
    started   = 1'b0;
    age       = 0;
    idle_from = 0;
    sticky    = 1'b0;
    busy_cnt  = 0;
  endtask

  task automatic randomize_pointers();
    for (int i = 0; i < NUM_REQ; i++) bus.req_pointer_i[i] = $urandom;
  endtask

  // Called at posedge+1: checks the grant, advances one clock, then checks outputs.
  task automatic tick();
    logic [NUM_REQ-1:0] exp_ready;
    logic [ID_W+31:0]   e;
    logic [31:0]        gptr;
    int  g;
    int  qs;
    bit  en, busy, s_pre, exp_done, exp_err, popped;
    #2;
    exp_ready = '0;
    g = -1;
    if (q.size() < DEPTH)
      for (int k = 0; k < NUM_REQ; k++)
        if (g < 0 && bus.req_valid_i[(rr + k) % NUM_REQ]) g = (rr + k) % NUM_REQ;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready_o), 64'(exp_ready));
    en    = bus.enable_i;
    busy  = bus.busy_i;
    qs    = q.size();
    s_pre = bus.start_o;
    gptr  = (g >= 0) ? bus.req_pointer_i[g] : 32'h0;
    @(posedge clk_i);
    cyc++;
    #1;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    popped   = 1'b0;
    if (inflight) begin
      if (!started) begin
        if (busy) started = 1'b1;
        else begin
          age++;
          if (age == START_TIMEOUT) begin
            exp_done = 1'b1; exp_err = 1'b1; inflight = 1'b0;
            sticky = 1'b1; idle_from = cyc + 2;
          end
        end
      end else if (!busy) begin
        exp_done = 1'b1; inflight = 1'b0; idle_from = cyc + 2;
      end
    end else if (cyc >= idle_from && en && qs > 0) begin
      e = q.pop_front();
      infl_id  = e[ID_W+31:32];
      infl_ptr = e[31:0];
      inflight = 1'b1; started = 1'b0; age = 0; popped = 1'b1;
    end
    if (g >= 0) begin
      q.push_back({ID_W'(g), gptr});
      rr = (g + 1) % NUM_REQ;
    end
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) bus.busy_i = 1'b0;
    end else if (s_pre && !busy && eng_alive) begin
      bus.busy_i = 1'b1;
      busy_cnt   = eng_len;
    end
    chk("start", 64'(bus.start_o), 64'(inflight && !started));
    if (inflight) chk(popped ? "task_pointer_pop" : "task_pointer_hold",
                      64'(bus.task_pointer_o), 64'(infl_ptr));
    chk("done_valid", 64'(bus.done_valid_o), 64'(exp_done));
    if (exp_done) begin
      chk("done_id", 64'(bus.done_id_o), 64'(infl_id));
      chk("done_err", 64'(bus.done_err_o), 64'(exp_err));
    end
    chk("error", 64'(bus.error_o), 64'(sticky));
    chk("queue_count", 64'(bus.queue_count_o), 64'(q.size()));
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((q.size() > 0 || inflight) && n < max) begin
      tick();
      n++;
    end
    chk("drain_bound", 64'(q.size() == 0 && !inflight), 64'd1);
  endtask

  initial begin
    int n;
    bus.enable_i      = 1'b0;
    bus.req_valid_i   = '0;
    bus.req_pointer_i = '0;
    bus.busy_i        = 1'b0;
    model_reset();

    // Reset state
    #2;
    chk("rst_start", 64'(bus.start_o), 64'd0);
    chk("rst_task_pointer", 64'(bus.task_pointer_o), 64'd0);
    chk("rst_done_valid", 64'(bus.done_valid_o), 64'd0);
    chk("rst_done_id", 64'(bus.done_id_o), 64'd0);
    chk("rst_done_err", 64'(bus.done_err_o), 64'd0);
    chk("rst_error", 64'(bus.error_o), 64'd0);
    chk("rst_queue_count", 64'(bus.queue_count_o), 64'd0);
    bus.req_valid_i = 4'b1111;
    #1;
    chk("rst_ready", 64'(bus.req_ready_o), 64'h1);
    bus.req_valid_i = 4'b0000;
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;

    // Single task from requester 2
    bus.enable_i = 1'b1;
    eng_len = 20;
    bus.req_valid_i = 4'b0100;
    bus.req_pointer_i[2] = 32'h0000_1000;
    tick();
    bus.req_valid_i = '0;
    drain(100);
    chk("single_empty", 64'(bus.queue_count_o), 64'd0);

    // Fairness and full boundary: all requesters valid continuously
    bus.req_valid_i = 4'b1111;
    for (int i = 0; i < 60; i++) begin
      eng_len = $urandom_range(1, 4);
      randomize_pointers();
      tick();
    end
    bus.req_valid_i = '0;
    drain(600);

    // Start timeout, then the next queued task still dispatches
    eng_alive = 1'b0;
    bus.req_valid_i = 4'b0001;
    randomize_pointers();
    tick();
    bus.req_valid_i = 4'b0010;
    tick();
    bus.req_valid_i = '0;
    n = 0;
    while (!sticky && n < 60) begin
      tick();
      n++;
    end
    chk("timeout_seen", 64'(sticky), 64'd1);
    eng_alive = 1'b1;
    eng_len = 3;
    drain(200);
    chk("error_sticky", 64'(bus.error_o), 64'd1);

    // Dispatch disabled with three tasks queued
    bus.enable_i = 1'b0;
    bus.req_valid_i = 4'b1000; randomize_pointers(); tick();
    bus.req_valid_i = 4'b0100; randomize_pointers(); tick();
    bus.req_valid_i = 4'b0001; randomize_pointers(); tick();
    bus.req_valid_i = '0;
    for (int i = 0; i < 10; i++) tick();
    chk("disabled_count", 64'(bus.queue_count_o), 64'd3);
    bus.enable_i = 1'b1;
    drain(200);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.req_valid_i = NUM_REQ'($urandom);
      bus.enable_i    = ($urandom_range(0, 3) != 0);
      eng_alive       = ($urandom_range(0, 7) != 0);
      eng_len         = $urandom_range(1, 6);
      randomize_pointers();
      tick();
    end
    bus.req_valid_i = '0;
    bus.enable_i    = 1'b1;
    eng_alive       = 1'b1;
    drain(1000);

    // Asynchronous reset during RUN with a task still queued
    eng_len = 20;
    bus.req_valid_i = 4'b0011;
    randomize_pointers();
    tick();
    tick();
    bus.req_valid_i = '0;
    n = 0;
    while (!(inflight && started) && n < 50) begin
      tick();
      n++;
    end
    chk("reached_run", 64'(inflight && started), 64'd1);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("arst_start", 64'(bus.start_o), 64'd0);
    chk("arst_task_pointer", 64'(bus.task_pointer_o), 64'd0);
    chk("arst_done_valid", 64'(bus.done_valid_o), 64'd0);
    chk("arst_error", 64'(bus.error_o), 64'd0);
    chk("arst_queue_count", 64'(bus.queue_count_o), 64'd0);
    bus.busy_i = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    bus.req_valid_i = 4'b1000;
    randomize_pointers();
    eng_len = 2;
    tick();
    bus.req_valid_i = '0;
    drain(100);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
